// File: rtl/planet_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : planet_regfile
//  Purpose  : Shared word store between the gravity FSM (6 lanes) and an
//             Avalon-MM host; START/DONE handshake and acc-clear sweep.
//  Option   : define REGFILE_BYPASS_EN for write-to-read forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module planet_regfile #(
    parameter int MAX_PLANETS = 10,
    parameter int DEPTH       = 4 + 11 * MAX_PLANETS
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AVL_CS,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic [6:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    input  logic [1:0]  FSM_re,
    input  logic [1:0]  FSM_we,
    input  logic [31:0] ADDR1,
    input  logic [31:0] ADDR2,
    input  logic [31:0] ADDR3,
    input  logic [31:0] ADDR4,
    input  logic [31:0] ADDR5,
    input  logic [31:0] ADDR6,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [31:0] DATA3,
    input  logic [31:0] DATA4,
    input  logic [31:0] DATA5,
    input  logic [31:0] DATA6,
    output logic [31:0] DATA1in,
    output logic [31:0] DATA2in,
    output logic [31:0] DATA3in,
    output logic [31:0] DATA4in,
    output logic [31:0] DATA5in,
    output logic [31:0] DATA6in,
    input  logic        FSM_DONE,
    input  logic        clear_accs,
    output logic        FSM_START,
    output logic [31:0] G,
    output logic [31:0] PLANET_NUM,
    output logic        CLR_BUSY
);

    localparam int c_LANES = 6;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_KW    = (MAX_PLANETS > 1) ? $clog2(MAX_PLANETS) : 1;
    localparam int c_ACC_X = 4 + 8 * MAX_PLANETS;
    localparam int c_ACC_Y = c_ACC_X + MAX_PLANETS;
    localparam int c_ACC_Z = c_ACC_Y + MAX_PLANETS;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWEEP = 1'b1;

    logic [31:0]     r_mem      [DEPTH];
    logic [31:0]     w_mem_nxt  [DEPTH];
    logic [31:0]     w_rd_src   [DEPTH];
    logic [31:0]     w_addr     [c_LANES];
    logic [31:0]     w_wdata    [c_LANES];
    logic [31:0]     w_lane_rd  [c_LANES];
    logic [31:0]     r_lane_q   [c_LANES];
    logic            w_lane_re  [c_LANES];
    logic            w_lane_we  [c_LANES];
    logic [31:0]     w_host_addr;
    logic [31:0]     w_host_rd;
    logic            w_host_we;
    logic [31:0]     r_avl_rdata;
    logic            r_fsm_start;
    logic [0:0]      r_clr_state;
    logic [c_KW-1:0] r_clr_idx;
    int              w_clr_k;

    assign w_addr[0]  = ADDR1;
    assign w_addr[1]  = ADDR2;
    assign w_addr[2]  = ADDR3;
    assign w_addr[3]  = ADDR4;
    assign w_addr[4]  = ADDR5;
    assign w_addr[5]  = ADDR6;
    assign w_wdata[0] = DATA1;
    assign w_wdata[1] = DATA2;
    assign w_wdata[2] = DATA3;
    assign w_wdata[3] = DATA4;
    assign w_wdata[4] = DATA5;
    assign w_wdata[5] = DATA6;

    // Lanes 1-3 follow enable bit 0, lanes 4-6 follow enable bit 1.
    generate
        for (genvar l = 0; l < c_LANES; l++) begin : g_lane_en
            assign w_lane_re[l] = (l < 3) ? FSM_re[0] : FSM_re[1];
            assign w_lane_we[l] = (l < 3) ? FSM_we[0] : FSM_we[1];
        end
    endgenerate

    assign w_host_we   = AVL_CS & AVL_WRITE;
    assign w_host_addr = {25'd0, AVL_ADDR};
    assign w_clr_k     = int'(r_clr_idx);

    // Next value of every word; later assignments take priority, so the
    // order below is host < sweep < start-clear < DONE set < lanes 1..6.
    always_comb begin
        for (int w = 0; w < DEPTH; w++) begin
            w_mem_nxt[w] = r_mem[w];
            if (w_host_we && (w_host_addr == 32'(w)))
                w_mem_nxt[w] = AVL_WRITEDATA;
            if ((r_clr_state == c_ST_SWEEP) &&
                ((w == c_ACC_X + w_clr_k) || (w == c_ACC_Y + w_clr_k) ||
                 (w == c_ACC_Z + w_clr_k)))
                w_mem_nxt[w] = '0;
            if (r_fsm_start && ((w == 2) || (w == 3)))
                w_mem_nxt[w] = '0;
            if (FSM_DONE && (w == 3))
                w_mem_nxt[w] = 32'd1;
            for (int l = 0; l < c_LANES; l++) begin
                if (w_lane_we[l] && (w_addr[l] == 32'(w)))
                    w_mem_nxt[w] = w_wdata[l];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_rd_src = w_mem_nxt;
`else
    assign w_rd_src = r_mem;
`endif

    always_comb begin
        for (int l = 0; l < c_LANES; l++) begin
            w_lane_rd[l] = '0;
            if (w_addr[l] < 32'(DEPTH))
                w_lane_rd[l] = w_rd_src[w_addr[l][c_AW-1:0]];
        end
        w_host_rd = '0;
        if (w_host_addr < 32'(DEPTH))
            w_host_rd = w_rd_src[w_host_addr[c_AW-1:0]];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int w = 0; w < DEPTH; w++)
                r_mem[w] <= '0;
        end else begin
            for (int w = 0; w < DEPTH; w++)
                r_mem[w] <= w_mem_nxt[w];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int l = 0; l < c_LANES; l++)
                r_lane_q[l] <= '0;
            r_avl_rdata <= '0;
        end else begin
            for (int l = 0; l < c_LANES; l++) begin
                if (w_lane_re[l])
                    r_lane_q[l] <= w_lane_rd[l];
            end
            if (AVL_CS && AVL_READ)
                r_avl_rdata <= w_host_rd;
        end
    end

    // The pulse cycle is also the cycle in which START/DONE are cleared.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_fsm_start <= 1'b0;
        else
            r_fsm_start <= w_host_we && (AVL_ADDR == 7'd2) && (AVL_WRITEDATA != 32'd0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clr_state <= c_ST_IDLE;
            r_clr_idx   <= '0;
        end else begin
            case (r_clr_state)
                c_ST_IDLE: begin
                    r_clr_idx <= '0;
                    if (clear_accs)
                        r_clr_state <= c_ST_SWEEP;
                end
                c_ST_SWEEP: begin
                    if (clear_accs) begin
                        r_clr_idx <= '0;
                    end else if (r_clr_idx == c_KW'(MAX_PLANETS - 1)) begin
                        r_clr_idx   <= '0;
                        r_clr_state <= c_ST_IDLE;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_KW'(1);
                    end
                end
                default: begin
                    r_clr_state <= c_ST_IDLE;
                    r_clr_idx   <= '0;
                end
            endcase
        end
    end

    assign DATA1in      = r_lane_q[0];
    assign DATA2in      = r_lane_q[1];
    assign DATA3in      = r_lane_q[2];
    assign DATA4in      = r_lane_q[3];
    assign DATA5in      = r_lane_q[4];
    assign DATA6in      = r_lane_q[5];
    assign AVL_READDATA = r_avl_rdata;
    assign FSM_START    = r_fsm_start;
    assign CLR_BUSY     = (r_clr_state == c_ST_SWEEP);
    assign G            = r_mem[0];
    assign PLANET_NUM   = r_mem[1];

endmodule
`default_nettype wire

// File: doc/planet_regfile.md
Name: planet_regfile

Overview:
- Shared state memory serving the gravity-simulation FSM (6-lane read/write port) and the host (Avalon-MM slave).
- Holds G, planet count, start/done control and per-planet mass/radius/position/velocity/acceleration words.
- Generates the FSM_START pulse, captures FSM_DONE, and performs a timed acceleration-clear sweep on clear_accs.

Parameters:
- MAX_PLANETS, 10, planets stored. Word map: 0=G, 1=NUM, 2=START, 3=DONE, then per-field blocks of MAX_PLANETS words starting at 4. Field order: mass, rad, pos xyz, vel xyz, acc xyz. Planet p (1..MAX_PLANETS) is at block_base+p-1.
- DEPTH, 4+11*MAX_PLANETS (114), words implemented.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- AVL_CS  in  1  host chip select
- AVL_READ  in  1  host read strobe
- AVL_WRITE  in  1  host write strobe
- AVL_ADDR  in  7  host word address
- AVL_WRITEDATA  in  32  host write data
- AVL_READDATA  out  32  host read data, valid 1 cycle after AVL_READ
- FSM_re  in  2  FSM read enable: 1=lanes1-3, 2=lanes4-6, 3=all
- FSM_we  in  2  FSM write enable, same encoding
- ADDR1..ADDR6  in  32 each  lane word addresses
- DATA1..DATA6  in  32 each  lane write data
- DATA1in..DATA6in  out  32 each  lane read data
- FSM_DONE  in  1  FSM completion pulse
- clear_accs  in  1  request acceleration-clear sweep
- FSM_START  out  1  one-cycle start pulse
- G  out  32  word 0, continuously
- PLANET_NUM  out  32  word 1, continuously
- CLR_BUSY  out  1  high while sweep active

Behaviour:
- Reset (RESET_N low, async): all words 0; DATA*in, AVL_READDATA, FSM_START, CLR_BUSY all 0; sweep counter 0.
- FSM read: enabled lanes register regfile[ADDRn] into DATAnin at the next CLK edge (1-cycle latency). Disabled lanes hold their last value.
- FSM write: each enabled lane writes DATAn to ADDRn at the CLK edge.
- Lane collision (same address, several enabled lanes): the highest-numbered lane wins.
- Host: when AVL_CS&AVL_WRITE, write word AVL_ADDR. When AVL_CS&AVL_READ, AVL_READDATA takes the word the next cycle; otherwise AVL_READDATA holds.
- Write priority on the same word, same cycle: FSM lane > clear sweep > host.
- Address >= DEPTH: writes ignored, reads return 0.
- Read-during-write to the same word returns the old contents.
- START handshake: a host write of a nonzero value to word 2 drives FSM_START=1 for exactly the next cycle. In that same cycle, word 2 auto-clears to 0 and word 3 (DONE) clears to 0.
- FSM_DONE=1 sets word 3 to 1. If FSM_DONE coincides with the start-pulse clear, the set wins.
- Clear sweep: states IDLE, SWEEP.
  - IDLE->SWEEP on clear_accs; planet index k=0.
  - In SWEEP, each cycle zeroes acc x, y and z of planet k+1, then k++.
  - SWEEP->IDLE after k=MAX_PLANETS-1, so the sweep lasts MAX_PLANETS cycles.
  - CLR_BUSY=1 exactly in SWEEP.
  - clear_accs asserted during SWEEP restarts at k=0.
  - Async reset mid-sweep returns to IDLE with all words 0.
- G and PLANET_NUM are combinational views of words 0 and 1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read (FSM lane or host) of a word written in the same cycle returns the newly written value, using the same write-priority rules.
- Undefined: returns old contents, per the read-during-write rule in Behaviour.

Test Plan:
- Reset: hold RESET_N low mid-cycle -> all DATAnin, AVL_READDATA, FSM_START and CLR_BUSY are 0 immediately. Host read of word 0 after release -> 0.
- Host writes word0=0x40800000, word1=4 -> G=0x40800000 and PLANET_NUM=4 on the following cycle. FSM_re=3 with ADDR1..6=0,1,4,14,24,34 -> DATA1in=0x40800000, DATA2in=4 one cycle later.
- Host writes word2=1 -> FSM_START high for exactly 1 cycle, then word2=0 and word3=0. Pulse FSM_DONE -> host read of word3 returns 1.
- FSM_we=3 with ADDR1=ADDR6=24, DATA1=0x3f800000, DATA6=0xbf800000, plus a host write to 24 the same cycle -> word24=0xbf800000.
- Preload acc words (MAX_PLANETS=10) with 0x3f800000, pulse clear_accs -> CLR_BUSY high for 10 cycles, all 30 acc words = 0, position words unchanged. Re-pulse at cycle 5 -> CLR_BUSY lasts 15 cycles total.
- FSM_we=1 writing 0x12345678 to word 44 while FSM_re=2 reads ADDR4=44 -> DATA4in = old value without REGFILE_BYPASS_EN, 0x12345678 with it. Read of ADDR=200 -> DATA4in=0.
